daq_scan_core: RTL and testbench

Parametrised multi-channel measurement sequencer, the next-generation data-acquisition core behind the APB wrapper. It sweeps a CPU-selected mask of up to NUM_CH sensor channels, once or continuously, issuing start pulses and timing out silent sensors. Results are tagged with their channel index and buffered in a first-word-fall-through FIFO, so the CPU can drain several measurements per poll. Status bits keep the existing busy/err/done semantics and add an overflow flag.

---
 rtl/daq_scan_core.sv | 218 +++++++++++++++++++++
 tb/tb_daq_scan_core.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_scan_core.sv
// Multi-channel measurement sequencer: sweeps a channel mask once or continuously, times out
// silent sensors and queues tagged results in a first-word-fall-through FIFO.
module daq_scan_core #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TO_W       = 12,
  parameter int unsigned IVL_W      = 16
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            CmdValid,
  output logic                            CmdReady,
  input  logic [1:0]                      CmdMode,
  input  logic [NUM_CH-1:0]               CmdChMask,
  input  logic [TO_W-1:0]                 CmdTimeout,
  input  logic [IVL_W-1:0]                CmdInterval,
  output logic [NUM_CH-1:0]               SensStart,
  input  logic [NUM_CH-1:0]               SensValid,
  input  logic [NUM_CH*DATA_W-1:0]        SensData,
  input  logic [NUM_CH*3-1:0]             SensErr,
  output logic                            ResultValid,
  output logic [31:0]                     ResultWord,
  input  logic                            ResultRd,
  output logic [$clog2(FIFO_DEPTH):0]     FifoLevel,
  input  logic                            StatusClear,
  output logic [3:0]                      StatusBits
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StAdvance, StGap} state_e;

  state_e              state_q, state_d;
  logic                cont_q, cont_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [TO_W-1:0]     tmo_q, tmo_d, tmr_q, tmr_d;
  logic [IVL_W-1:0]    ivl_q, ivl_d, gap_q, gap_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   sens_start_q, sens_start_d;
  logic                done_q, done_d, err_q, err_d, ovf_q, ovf_d;

  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]         cnt_q, cnt_d;

  logic                cmd_fire, start_cmd, stop_cmd;
  logic                ch_valid, timed_out, push_req, push, pop, full, empty, done_set;
  logic [DATA_W-1:0]   sel_data;
  logic [2:0]          push_err;
  logic [31:0]         push_word;
  logic                nxt_found;
  logic [CH_W-1:0]     nxt_ch;

  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    logic found;
    found  = 1'b0;
    lowest = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m[i] && !found) begin
        found  = 1'b1;
        lowest = CH_W'(i);
      end
    end
  endfunction

  assign CmdReady  = (state_q == StIdle) || cont_q;
  assign cmd_fire  = CmdValid && CmdReady;
  assign start_cmd = cmd_fire && (state_q == StIdle) && (CmdMode == 2'b01 || CmdMode == 2'b10)
                     && (|CmdChMask);
  assign stop_cmd  = cmd_fire && cont_q && (CmdMode == 2'b00);

  // Result capture for the channel under measurement; a valid in the timeout cycle wins.
  assign ch_valid  = SensValid[ch_q];
  assign timed_out = (tmo_q != '0) && (tmr_q == tmo_q - 1'b1);
  assign push_req  = (state_q == StWait) && (ch_valid || timed_out);
  assign sel_data  = SensData[ch_q*DATA_W +: DATA_W];
  assign push_err  = ch_valid ? SensErr[ch_q*3 +: 3] : 3'b110;
  assign push_word = {ch_valid ? 16'(sel_data) : 16'h0000, push_err, 5'b0_0000, 7'(ch_q), 1'b1};

  assign full  = (cnt_q == FullCnt);
  assign empty = (cnt_q == '0);
  assign pop   = ResultRd && !empty;
  assign push  = push_req && (!full || pop);

  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = ch_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!nxt_found && mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    mask_d   = mask_q;
    tmo_d    = tmo_q;
    ivl_d    = ivl_q;
    tmr_d    = tmr_q;
    gap_d    = gap_q;
    ch_d     = ch_q;
    done_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_cmd) begin
          cont_d  = (CmdMode == 2'b10);
          mask_d  = CmdChMask;
          tmo_d   = CmdTimeout;
          ivl_d   = CmdInterval;
          ch_d    = lowest(CmdChMask);
          state_d = StStart;
        end
      end
      StStart: begin
        tmr_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        tmr_d = tmr_q + 1'b1;
        if (push_req) state_d = StAdvance;
      end
      StAdvance: begin
        if (nxt_found) begin
          ch_d    = nxt_ch;
          state_d = StStart;
        end else begin
          done_set = 1'b1;
          if (!cont_q) begin
            state_d = StIdle;
          end else if (ivl_q == '0) begin
            ch_d    = lowest(mask_q);
            state_d = StStart;
          end else begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == ivl_q - 1'b1) begin
          ch_d    = lowest(mask_q);
          state_d = StStart;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A stop overrides sequencing but leaves any same-cycle push intact.
    if (stop_cmd) state_d = StIdle;
    if (state_d == StIdle) cont_d = 1'b0;
  end

  always_comb begin
    sens_start_d = (state_d == StStart) ? (NUM_CH'(1) << ch_d) : '0;
    done_d = done_set | (done_q & ~StatusClear);
    err_d  = (push_req && push_err != 3'b001) | (err_q & ~StatusClear);
    ovf_d  = (push_req && full && !pop) | (ovf_q & ~StatusClear);
    wp_d   = push ? wp_q + 1'b1 : wp_q;
    rp_d   = pop ? rp_q + 1'b1 : rp_q;
    cnt_d  = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= StIdle;
      cont_q       <= 1'b0;
      mask_q       <= '0;
      tmo_q        <= '0;
      ivl_q        <= '0;
      tmr_q        <= '0;
      gap_q        <= '0;
      ch_q         <= '0;
      sens_start_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      mask_q       <= mask_d;
      tmo_q        <= tmo_d;
      ivl_q        <= ivl_d;
      tmr_q        <= tmr_d;
      gap_q        <= gap_d;
      ch_q         <= ch_d;
      sens_start_q <= sens_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wp_q] <= push_word;
  end

  assign SensStart   = sens_start_q;
  assign ResultValid = !empty;
  assign ResultWord  = empty ? 32'h0 : mem_q[rp_q];
  assign FifoLevel   = cnt_q;
  assign StatusBits  = {ovf_q, (state_q != StIdle), err_q, done_q};

endmodule

// File: tb/tb_daq_scan_core.sv
// Directed-plus-random bench for daq_scan_core; a queue-based model predicts FIFO words,
// sticky bits and the cycle on which each start pulse must appear.
module tb_daq_scan_core;
  localparam int NUM_CH = 8, DATA_W = 16, FIFO_DEPTH = 4, TO_W = 12, IVL_W = 16;

  logic                       Clk = 1'b0;
  logic                       Rst;
  logic                       CmdValid, CmdReady;
  logic [1:0]                 CmdMode;
  logic [NUM_CH-1:0]          CmdChMask;
  logic [TO_W-1:0]            CmdTimeout;
  logic [IVL_W-1:0]           CmdInterval;
  logic [NUM_CH-1:0]          SensStart, SensValid;
  logic [NUM_CH*DATA_W-1:0]   SensData;
  logic [NUM_CH*3-1:0]        SensErr;
  logic                       ResultValid, ResultRd, StatusClear;
  logic [31:0]                ResultWord;
  logic [$clog2(FIFO_DEPTH):0] FifoLevel;
  logic [3:0]                 StatusBits;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mq[$];
  bit          m_done, m_err, m_ovf;

  always #5 Clk = ~Clk;

  daq_scan_core #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TO_W(TO_W), .IVL_W(IVL_W)
  ) dut (
    .Clk(Clk), .Rst(Rst), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdMode(CmdMode),
    .CmdChMask(CmdChMask), .CmdTimeout(CmdTimeout), .CmdInterval(CmdInterval),
    .SensStart(SensStart), .SensValid(SensValid), .SensData(SensData), .SensErr(SensErr),
    .ResultValid(ResultValid), .ResultWord(ResultWord), .ResultRd(ResultRd),
    .FifoLevel(FifoLevel), .StatusClear(StatusClear), .StatusBits(StatusBits)
  );

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    CmdValid    = 1'b0;
    ResultRd    = 1'b0;
    StatusClear = 1'b0;
    SensValid   = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input int c, input logic [15:0] d, input logic [2:0] e);
    return {d, e, 5'b0, 7'(c), 1'b1};
  endfunction

  function automatic logic [2:0] rnd_err();
    return ($urandom % 3 == 0) ? 3'($urandom) : 3'b001;
  endfunction

  task automatic model_push(input logic [31:0] w);
    if (w[15:13] != 3'b001) m_err = 1'b1;
    if (mq.size() == FIFO_DEPTH) m_ovf = 1'b1;
    else mq.push_back(w);
  endtask

  task automatic chk_status(input bit busy);
    check("status", 32'(StatusBits), {28'h0, m_ovf, busy, m_err, m_done});
    check("level", 32'(FifoLevel), mq.size());
  endtask

  task automatic issue(input logic [1:0] mode, input logic [7:0] mask, input int t, input int ivl);
    CmdValid    = 1'b1;
    CmdMode     = mode;
    CmdChMask   = mask;
    CmdTimeout  = TO_W'(t);
    CmdInterval = IVL_W'(ivl);
    check("cmd_ready", 32'(CmdReady), 1);
    tick();
  endtask

  // Entered in the START cycle of channel c; returns in the cycle after the push.
  task automatic serve(input int c, input int lat, input int t, input logic [15:0] d,
                       input logic [2:0] e, input bit pop);
    logic [7:0]  noise;
    logic [31:0] w;
    check("start_pulse", 32'(SensStart), 32'(8'd1 << c));
    check("start_busy", 32'(StatusBits[2]), 1);
    tick();
    for (int i = 0; i < 1000; i++) begin
      check("wait_quiet", 32'(SensStart), 0);
      noise      = 8'($urandom);
      noise[c]   = 1'b0;
      SensValid  = noise;
      SensData   = {$urandom, $urandom, $urandom, $urandom};
      SensErr    = 24'($urandom);
      if (i == lat && (t == 0 || lat < t)) begin
        SensValid[c]         = 1'b1;
        SensData[c*16 +: 16] = d;
        SensErr[c*3 +: 3]    = e;
        w = mk_word(c, d, e);
      end else if (t != 0 && i == t - 1) begin
        w = mk_word(c, 16'h0000, 3'b110);
      end else begin
        tick();
        continue;
      end
      if (pop) begin
        ResultRd = 1'b1;
        if (mq.size() > 0) begin
          check("pop_head", ResultWord, mq[0]);
          void'(mq.pop_front());
        end
      end
      model_push(w);
      tick();
      return;
    end
  endtask

  task automatic sweep(input logic [7:0] mask, input int t, input int lat_max);
    bit first = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        if (!first) tick();
        first = 1'b0;
        serve(c, $urandom_range(lat_max, 0), t, 16'($urandom), rnd_err(), ($urandom % 2) == 1);
      end
    end
  endtask

  task automatic drain();
    while (mq.size() > 0) begin
      check("drain_valid", 32'(ResultValid), 1);
      check("drain_word", ResultWord, mq[0]);
      check("drain_level", 32'(FifoLevel), mq.size());
      ResultRd = 1'b1;
      void'(mq.pop_front());
      tick();
    end
    ResultRd = 1'b1;
    tick();
    check("empty_valid", 32'(ResultValid), 0);
    check("empty_word", ResultWord, 0);
    check("empty_level", 32'(FifoLevel), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(SensStart), 0);
    check({tag, "_rvalid"}, 32'(ResultValid), 0);
    check({tag, "_word"}, ResultWord, 0);
    check({tag, "_level"}, 32'(FifoLevel), 0);
    check({tag, "_status"}, 32'(StatusBits), 0);
    check({tag, "_ready"}, 32'(CmdReady), 1);
  endtask

  initial begin
    logic [7:0] mask, lo;
    int         t, ivl;

    Rst = 1'b1; CmdValid = 1'b0; CmdMode = '0; CmdChMask = '0; CmdTimeout = '0;
    CmdInterval = '0; SensValid = '0; SensData = '0; SensErr = '0; ResultRd = 1'b0;
    StatusClear = 1'b0;
    tick();
    tick();
    chk_reset_outputs("in_reset");
    Rst = 1'b0;
    tick();
    chk_reset_outputs("post_reset");

    // Reserved mode and empty mask are accepted without starting a sweep.
    issue(2'b11, 8'hFF, 0, 0);
    check("mode11_idle", 32'(StatusBits[2]), 0);
    issue(2'b01, 8'h00, 0, 0);
    check("zero_mask_idle", 32'(StatusBits[2]), 0);
    check("zero_mask_start", 32'(SensStart), 0);

    // Directed single sweep over channels 0 and 2.
    issue(2'b01, 8'h05, 0, 0);
    serve(0, 0, 0, 16'h0ABC, 3'b001, 1'b0);
    check("first_result_valid", 32'(ResultValid), 1);
    tick();
    serve(2, 2, 0, 16'h0123, 3'b001, 1'b0);
    tick();
    m_done = 1'b1;
    chk_status(1'b0);
    check("tp1_head", ResultWord, 32'h0ABC_2001);
    drain();

    // Timeout after exactly five WAIT cycles, then a valid in the fifth cycle wins.
    issue(2'b01, 8'h08, 5, 0);
    serve(3, 99, 5, 16'h0000, 3'b001, 1'b0);
    tick();
    chk_status(1'b0);
    check("to_word", ResultWord, 32'h0000_C007);
    drain();
    issue(2'b01, 8'h08, 5, 0);
    serve(3, 4, 5, 16'h5A5A, 3'b001, 1'b0);
    StatusClear = 1'b1;
    tick();
    m_done = 1'b1; m_err = 1'b0; m_ovf = 1'b0;
    chk_status(1'b0);
    check("late_valid_word", ResultWord, 32'h5A5A_2007);
    drain();
    StatusClear = 1'b1;
    tick();
    m_done = 1'b0;
    check("clear_all", 32'(StatusBits), 0);

    // Random single sweeps.
    for (int it = 0; it < 6; it++) begin
      mask = 8'($urandom);
      if (mask == 8'h00) mask = 8'h40;
      t = $urandom_range(6, 0);
      issue(2'b01, mask, t, 0);
      sweep(mask, t, (t == 0) ? 5 : t + 2);
      if (it == 2) begin
        StatusClear = 1'b1;
        m_err = 1'b0;
        m_ovf = 1'b0;
      end
      tick();
      m_done = 1'b1;
      chk_status(1'b0);
      if (it % 2 == 1) drain();
    end
    drain();
    StatusClear = 1'b1;
    tick();
    m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    chk_status(1'b0);

    // Continuous on channel 0 with interval 2: overflow, pop-while-full, then stop mid-WAIT.
    issue(2'b10, 8'h01, 0, 2);
    for (int k = 0; k < 5; k++) begin
      serve(0, $urandom_range(2, 0), 0, 16'($urandom), 3'b001, 1'b0);
      if (k == 4) begin
        chk_status(1'b1);
        check("ovf_level", 32'(FifoLevel), 4);
      end
      tick();
      m_done = 1'b1;
      check("gap_ready", 32'(CmdReady), 1);
      check("gap_quiet", 32'(SensStart), 0);
      if (k == 4) begin
        StatusClear = 1'b1;
        m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
      end
      tick();
      check("gap_quiet2", 32'(SensStart), 0);
      tick();
    end
    serve(0, 1, 0, 16'hBEEF, 3'b001, 1'b1);
    chk_status(1'b1);
    tick();
    m_done = 1'b1;
    tick();
    tick();
    check("cont_restart", 32'(SensStart), 1);
    tick();
    SensValid[0] = 1'b1;
    SensData[15:0] = 16'h7777;
    SensErr[2:0] = 3'b001;
    ResultRd = 1'b1;
    check("stop_pop_head", ResultWord, mq[0]);
    void'(mq.pop_front());
    model_push(mk_word(0, 16'h7777, 3'b001));
    issue(2'b00, 8'h00, 0, 0);
    chk_status(1'b0);
    check("stop_ready", 32'(CmdReady), 1);
    for (int k = 0; k < 4; k++) begin
      check("stop_quiet", 32'(SensStart), 0);
      tick();
    end
    drain();

    // Random continuous runs, stopped right after the second sweep ends.
    for (int it = 0; it < 4; it++) begin
      mask = 8'($urandom);
      if (mask == 8'h00) mask = 8'h80;
      lo  = mask & (~mask + 8'd1);
      t   = $urandom_range(4, 0);
      ivl = $urandom_range(3, 0);
      issue(2'b10, mask, t, ivl);
      for (int s = 0; s < 2; s++) begin
        sweep(mask, t, (t == 0) ? 4 : t + 1);
        tick();
        m_done = 1'b1;
        check("cont_ready", 32'(CmdReady), 1);
        if (s == 0) begin
          for (int g = 0; g < ivl; g++) begin
            check("rgap_quiet", 32'(SensStart), 0);
            tick();
          end
        end
      end
      check("stop_edge_pulse", 32'(SensStart), (ivl == 0) ? 32'(lo) : 32'h0);
      issue(2'b00, 8'h00, 0, 0);
      chk_status(1'b0);
      drain();
    end

    // Reset in the middle of a sweep with two results queued.
    issue(2'b01, 8'h0B, 0, 0);
    serve(0, 1, 0, 16'h1111, 3'b011, 1'b0);
    tick();
    serve(1, 0, 0, 16'h2222, 3'b001, 1'b0);
    tick();
    check("pre_reset_level", 32'(FifoLevel), 2);
    Rst = 1'b1;
    tick();
    chk_reset_outputs("mid_reset");
    Rst = 1'b0;
    mq.delete();
    m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    tick();
    chk_reset_outputs("after_mid_reset");

    issue(2'b01, 8'h10, 0, 0);
    serve(4, 0, 0, 16'hC0DE, 3'b001, 1'b0);
    tick();
    m_done = 1'b1;
    chk_status(1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
